// File: rtl/button_debounce_repeat_if.sv
// Button conditioner port bundle: run enable and raw buttons in, tick, clean level and strobes out.
// `release` is a reserved word, so the release strobe is carried as release_stb.
interface button_debounce_repeat_if #(
   parameter int N_BTN = 5
);
   logic             en;
   logic [N_BTN-1:0] btn_raw;
   logic             tick;
   logic [N_BTN-1:0] level;
   logic [N_BTN-1:0] press;
   logic [N_BTN-1:0] release_stb;
   logic [N_BTN-1:0] action;

   modport master (
      output en, btn_raw,
      input  tick, level, press, release_stb, action
   );

   modport slave (
      input  en, btn_raw,
      output tick, level, press, release_stb, action
   );
endinterface

// File: rtl/button_debounce_repeat.sv
// N-channel push-button conditioner: sample-tick prescaler, 2-flop synchroniser, debounce filter and
// hold/auto-repeat FSM per channel, giving clean levels plus press, release and action strobes.
module button_debounce_repeat #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int TICK_US      = 1000,
   parameter int N_BTN        = 5,
   parameter int STABLE_TICKS = 10,
   parameter int HOLD_TICKS   = 500,
   parameter int REPEAT_TICKS = 100
) (
   input logic                     clk,
   input logic                     rst,
   button_debounce_repeat_if.slave bus
);

   localparam int DIV    = CLK_HZ / 1_000_000 * TICK_US;
   localparam int PW     = $clog2(DIV);
   localparam int DCW    = $clog2(STABLE_TICKS + 1);
   localparam int MAX_HR = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
   localparam int HCW    = $clog2(MAX_HR + 1);

   // Terminal counts: comparing against N-1 is the same as testing count+1 == N without a carry bit.
   localparam logic [PW-1:0]  DIV_M1    = PW'(DIV - 1);
   localparam logic [DCW-1:0] STABLE_M1 = DCW'(STABLE_TICKS - 1);
   localparam logic [HCW-1:0] HOLD_M1   = HCW'(HOLD_TICKS - 1);
   localparam logic [HCW-1:0] RPT_M1    = HCW'(REPEAT_TICKS - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_RPT  = 2'd2;

   logic [PW-1:0]              pcnt_q,  pcnt_d;
   logic                       tick;
   logic [N_BTN-1:0]           sync1_q, sync1_d;
   logic [N_BTN-1:0]           sync2_q, sync2_d;
   logic [N_BTN-1:0]           level_q, level_d;
   logic [N_BTN-1:0][DCW-1:0]  dcnt_q,  dcnt_d;
   logic [N_BTN-1:0]           press_q, press_d;
   logic [N_BTN-1:0]           rel_q,   rel_d;
   logic [N_BTN-1:0]           rpt_q,   rpt_d;
   logic [N_BTN-1:0][1:0]      st_q,    st_d;
   logic [N_BTN-1:0][HCW-1:0]  hcnt_q,  hcnt_d;
   logic [N_BTN-1:0]           rise,    fall;

   // Prescaler: free-running 0..DIV-1 while enabled, frozen otherwise.
   always_comb begin
      tick   = bus.en && (pcnt_q == DIV_M1);
      pcnt_d = pcnt_q;
      if (bus.en) begin
         pcnt_d = (pcnt_q == DIV_M1) ? '0 : pcnt_q + PW'(1);
      end
   end

   // The synchroniser runs regardless of en so the sampled level is never stale on resume.
   always_comb begin
      sync1_d = bus.btn_raw;
      sync2_d = sync1_q;
   end

   // NOTE: every signal written here gets a default first, so no path can leave it unassigned (no latch).
   always_comb begin
      level_d = level_q;
      dcnt_d  = dcnt_q;
      rise    = '0;
      fall    = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (tick) begin
            if (sync2_q[i] != level_q[i]) begin
               if (dcnt_q[i] == STABLE_M1) begin
                  level_d[i] = ~level_q[i];
                  dcnt_d[i]  = '0;
                  rise[i]    = ~level_q[i];
                  fall[i]    = level_q[i];
               end else begin
                  dcnt_d[i] = dcnt_q[i] + DCW'(1);
               end
            end else begin
               dcnt_d[i] = '0;
            end
         end
      end
      press_d = rise;
      rel_d   = fall;
   end

   // Repeat FSM keys off the same-edge rise/fall, so a release on a repeat boundary suppresses the repeat.
   always_comb begin
      st_d   = st_q;
      hcnt_d = hcnt_q;
      rpt_d  = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (fall[i]) begin
            st_d[i]   = ST_IDLE;
            hcnt_d[i] = '0;
         end else if (rise[i]) begin
            st_d[i]   = ST_HOLD;
            hcnt_d[i] = '0;
         end else if (tick) begin
            case (st_q[i])
               ST_IDLE: ;
               ST_HOLD: begin
                  if (hcnt_q[i] == HOLD_M1) begin
                     rpt_d[i]  = 1'b1;
                     st_d[i]   = ST_RPT;
                     hcnt_d[i] = '0;
                  end else begin
                     hcnt_d[i] = hcnt_q[i] + HCW'(1);
                  end
               end
               ST_RPT: begin
                  if (hcnt_q[i] == RPT_M1) begin
                     rpt_d[i]  = 1'b1;
                     hcnt_d[i] = '0;
                  end else begin
                     hcnt_d[i] = hcnt_q[i] + HCW'(1);
                  end
               end
               default: begin
                  st_d[i]   = ST_IDLE;
                  hcnt_d[i] = '0;
               end
            endcase
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt_q  <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         dcnt_q  <= '0;
         press_q <= '0;
         rel_q   <= '0;
         rpt_q   <= '0;
         st_q    <= {N_BTN{ST_IDLE}};
         hcnt_q  <= '0;
      end else begin
         pcnt_q  <= pcnt_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         dcnt_q  <= dcnt_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         rpt_q   <= rpt_d;
         st_q    <= st_d;
         hcnt_q  <= hcnt_d;
      end
   end

   // Strobes are masked while disabled; level simply holds.
   assign bus.tick        = tick;
   assign bus.level       = level_q;
   assign bus.press       = press_q & {N_BTN{bus.en}};
   assign bus.release_stb = rel_q & {N_BTN{bus.en}};
   assign bus.action      = (press_q | rpt_q) & {N_BTN{bus.en}};

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Directed bench for button_debounce_repeat with DIV=10, STABLE=3, HOLD=5, REPEAT=2, two channels.
// cyc counts rising edges since the latest reset release; all driving and sampling happens 1 ns after an edge.
module tb_button_debounce_repeat;
   localparam int N_BTN = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   button_debounce_repeat_if #(.N_BTN(N_BTN)) bus ();

   button_debounce_repeat #(
      .CLK_HZ       (10_000_000),
      .TICK_US      (1),
      .N_BTN        (N_BTN),
      .STABLE_TICKS (3),
      .HOLD_TICKS   (5),
      .REPEAT_TICKS (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s at cyc %0d: observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_level"}, bus.level, 2'b00);
      check({tag, "_press"}, bus.press, 2'b00);
      check({tag, "_release"}, bus.release_stb, 2'b00);
      check({tag, "_action"}, bus.action, 2'b00);
      check({tag, "_tick"}, {1'b0, bus.tick}, 2'b00);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] exp_act;
      logic [1:0] exp_rel;
      logic [1:0] exp_lvl;

      // Reset state
      rst         = 1'b1;
      bus.en      = 1'b1;
      bus.btn_raw = 2'b00;
      repeat (3) step();
      check_all_zero("reset");
      rst = 1'b0;
      cyc = 0;

      // Idle: tick at 9, 19, 29, ... and everything else quiet
      for (int c = 1; c < 40; c++) begin
         step();
         check("t1_tick", {1'b0, bus.tick}, {1'b0, (cyc % 10) == 9});
         check("t1_quiet", bus.level | bus.press | bus.release_stb | bus.action, 2'b00);
      end

      // Clean press on channel 0 at cyc 40: tick edges 50, 60, 70 -> level up at 70
      run_to(40);
      bus.btn_raw = 2'b01;
      while (cyc < 69) begin
         step();
         check("t2_level_low", bus.level, 2'b00);
         check("t2_press_low", bus.press, 2'b00);
      end
      step();
      check("t2_level", bus.level, 2'b01);
      check("t2_press", bus.press, 2'b01);
      check("t2_action", bus.action, 2'b01);
      check("t2_release", bus.release_stb, 2'b00);

      // Hold: repeats at 120 (press+5 ticks) then every 20 clks; drop at 250 -> release at 280,
      // which lands on a repeat boundary and must not produce an action.
      while (cyc < 290) begin
         step();
         exp_act = (cyc >= 120 && cyc <= 260 && (cyc - 120) % 20 == 0) ? 2'b01 : 2'b00;
         exp_rel = (cyc == 280) ? 2'b01 : 2'b00;
         exp_lvl = (cyc < 280) ? 2'b01 : 2'b00;
         check("t4_action", bus.action, exp_act);
         check("t4_release", bus.release_stb, exp_rel);
         check("t4_level", bus.level, exp_lvl);
         check("t4_press", bus.press, 2'b00);
         if (cyc == 250) bus.btn_raw = 2'b00;
      end

      // Bounce: toggle every 15 clks from 300, last edge at 390 -> level up at 420, one press
      run_to(300);
      while (cyc < 420) begin
         bus.btn_raw = {1'b0, (cyc >= 390) || (((cyc - 300) / 15) % 2 == 0)};
         check("t3_level_low", bus.level, 2'b00);
         check("t3_press_low", bus.press, 2'b00);
         step();
      end
      check("t3_level", bus.level, 2'b01);
      check("t3_press", bus.press, 2'b01);
      step();
      check("t3_press_once", bus.press, 2'b00);

      // First repeat at 470, then reset mid-RPT at 480
      run_to(470);
      check("t5_repeat", bus.action, 2'b01);
      run_to(480);
      check("t5_pre_level", bus.level, 2'b01);
      rst = 1'b1;
      #1;
      check_all_zero("t5_rst_async");
      repeat (3) begin
         step();
         check("t5_rst_level", bus.level, 2'b00);
      end
      rst = 1'b0;
      cyc = 0;
      while (cyc < 29) begin
         step();
         check("t5_level_low", bus.level, 2'b00);
         check("t5_press_low", bus.press, 2'b00);
      end
      step();
      check("t5_level", bus.level, 2'b01);
      check("t5_press", bus.press, 2'b01);
      check("t5_action", bus.action, 2'b01);

      // Release channel 0 at 40 -> release at 70
      run_to(40);
      bus.btn_raw = 2'b00;
      run_to(70);
      check("t6_release", bus.release_stb, 2'b01);
      check("t6_rel_level", bus.level, 2'b00);
      check("t6_rel_action", bus.action, 2'b00);

      // Both pressed at 80: dcnt reaches 2 at edge 100. Freeze at 103 (prescaler at 3) for 55 clks;
      // resumes at 158 from 3 -> tick at 164 -> both levels up at 165.
      run_to(80);
      bus.btn_raw = 2'b11;
      run_to(103);
      bus.en = 1'b0;
      while (cyc < 158) begin
         step();
         check("t6_frozen_tick", {1'b0, bus.tick}, 2'b00);
         check("t6_frozen_level", bus.level, 2'b00);
      end
      bus.en = 1'b1;
      while (cyc < 164) begin
         check("t6_resume_press_low", bus.press, 2'b00);
         step();
      end
      check("t6_resume_tick", {1'b0, bus.tick}, 2'b01);
      check("t6_resume_press_low", bus.press, 2'b00);
      step();
      check("t6_press_both", bus.press, 2'b11);
      check("t6_action_both", bus.action, 2'b11);
      check("t6_level_both", bus.level, 2'b11);
      step();
      check("t6_press_end", bus.press, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
